// File: rtl/hex_capture_display.sv
// hex_capture_display: captures nibbles from the mux `chosen` output into a
// 4-deep history buffer and scans them onto a 4-digit common-anode display.
// Optional build macro HEX_SCAN_GUARD_EN inserts a 1-cycle all-off blanking
// slot on every scan advance to suppress ghosting between digits.
module hex_capture_display #(
    parameter int REFRESH_CYCLES = 50000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] din,
    input  logic       capture,
    input  logic       clear,
    output logic [6:0] hex_seg,
    output logic [3:0] digit_en,
    output logic [2:0] count,
    output logic       full,
    output logic       overflow
);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } scan_t;

    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);

    logic [3:0][3:0] hist_q, hist_d;
    logic [2:0]      count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            capture_q;
    logic [CNT_W-1:0] refCnt_q, refCnt_d;
    scan_t           scan_q, scan_d;
    logic [6:0]      seg_q, seg_d;
    logic [3:0]      en_q, en_d;

    logic            capPulse;
    logic            refWrap;
    logic [1:0]      scanIdx;

    assign capPulse = capture & ~capture_q;
    assign refWrap  = (refCnt_q == REF_LAST);
    assign scanIdx  = scan_q;

    assign hex_seg  = seg_q;
    assign digit_en = en_q;
    assign count    = count_q;
    assign full     = (count_q == 3'd4);
    assign overflow = overflow_q;

    // Segment pattern for one hex digit; active-low, bit0 = a ... bit6 = g.
    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // History buffer: clear wins over a capture edge; a capture while full only flags overflow.
    always_comb begin
        hist_d     = hist_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            hist_d     = '0;
            count_d    = 3'd0;
            overflow_d = 1'b0;
        end else if (capPulse) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                hist_d[3] = hist_q[2];
                hist_d[2] = hist_q[1];
                hist_d[1] = hist_q[0];
                hist_d[0] = din;
                count_d   = count_q + 3'd1;
            end
        end
    end

    // Refresh timer: free-running 0..REFRESH_CYCLES-1, independent of clear.
    always_comb begin
        refCnt_d = refWrap ? '0 : refCnt_q + 1'b1;
    end

    // Scan next-state and next output values; the outputs reflect the current digit one cycle later.
    always_comb begin
        scan_d = scan_q;
        if (refWrap) begin
            unique case (scan_q)
                DIG0:    scan_d = DIG1;
                DIG1:    scan_d = DIG2;
                DIG2:    scan_d = DIG3;
                default: scan_d = DIG0;
            endcase
        end

        en_d          = 4'hF;
        en_d[scanIdx] = 1'b0;
        seg_d         = ({1'b0, scanIdx} < count_q) ? font(hist_q[scanIdx]) : 7'h7F;
`ifdef HEX_SCAN_GUARD_EN
        if (refWrap) begin
            en_d  = 4'hF;
            seg_d = 7'h7F;
        end
`endif
    end

    // State and output registers; reset drops everything to a dark, empty display.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q     <= '0;
            count_q    <= 3'd0;
            overflow_q <= 1'b0;
            capture_q  <= 1'b0;
            refCnt_q   <= '0;
            scan_q     <= DIG0;
            seg_q      <= 7'h7F;
            en_q       <= 4'hF;
        end else begin
            hist_q     <= hist_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            capture_q  <= capture;
            refCnt_q   <= refCnt_d;
            scan_q     <= scan_d;
            seg_q      <= seg_d;
            en_q       <= en_d;
        end
    end

endmodule

// File: tb/tb_hex_capture_display.sv
// Testbench for hex_capture_display with a short refresh period so the scan
// can be observed quickly. Honours HEX_SCAN_GUARD_EN when the build defines it.
module tb_hex_capture_display;

    localparam int R     = 4;
    localparam int CNT_W = 3;

    logic       clk;
    logic       reset;
    logic [3:0] din;
    logic       capture;
    logic       clear;
    logic [6:0] hex_seg;
    logic [3:0] digit_en;
    logic [2:0] count;
    logic       full;
    logic       overflow;

    int total = 0;
    int bad   = 0;

    // Behavioural reference: edges since reset, nibble history (newest first), flags.
    int         k;
    logic [3:0] mHist [4];
    int         mCnt;
    bit         mOvf;
    bit         mPrev;

    logic [6:0] fontTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [3:0] din;
        bit         cap;
        bit         clr;
        int         eCount;
        bit         eFull;
        bit         eOvf;
    } vec_t;

    vec_t vecs [15];

    hex_capture_display #(
        .REFRESH_CYCLES(R),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .din(din),
        .capture(capture),
        .clear(clear),
        .hex_seg(hex_seg),
        .digit_en(digit_en),
        .count(count),
        .full(full),
        .overflow(overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] d, input bit cap, input bit clr);
        din     = d;
        capture = cap;
        clear   = clr;
    endtask

    task automatic modelReset();
        k     = 0;
        mCnt  = 0;
        mOvf  = 0;
        mPrev = 0;
        for (int j = 0; j < 4; j++) mHist[j] = 4'h0;
    endtask

    // One clock: predict outputs from the model, clock the DUT, compare 1 ns after the edge.
    task automatic tick();
        int         idx;
        logic [3:0] eEn;
        logic [6:0] eSeg;
        bit         pulse;
        idx       = (k / R) % 4;
        eEn       = 4'hF;
        eEn[idx]  = 1'b0;
        eSeg      = (idx < mCnt) ? fontTab[mHist[idx]] : 7'h7F;
`ifdef HEX_SCAN_GUARD_EN
        if ((k % R) == R - 1) begin
            eEn  = 4'hF;
            eSeg = 7'h7F;
        end
`endif
        pulse = capture && !mPrev;
        if (clear) begin
            mCnt = 0;
            mOvf = 0;
            for (int j = 0; j < 4; j++) mHist[j] = 4'h0;
        end else if (pulse) begin
            if (mCnt == 4) begin
                mOvf = 1;
            end else begin
                for (int j = 3; j > 0; j--) mHist[j] = mHist[j-1];
                mHist[0] = din;
                mCnt++;
            end
        end
        mPrev = capture;
        k++;
        @(posedge clk);
        #1;
        checkOutput("hex_seg", 32'(hex_seg), 32'(eSeg));
        checkOutput("digit_en", 32'(digit_en), 32'(eEn));
        checkOutput("count", 32'(count), 32'(mCnt));
        checkOutput("full", 32'(full), 32'(mCnt == 4));
        checkOutput("overflow", 32'(overflow), 32'(mOvf));
    endtask

    initial begin
        logic [3:0] seqN [4];
        logic [6:0] seen [4];
        logic [6:0] wantSeen [4];
        int         n;

        vecs[0]  = '{4'hA, 1, 0, 1, 0, 0};
        vecs[1]  = '{4'h3, 1, 0, 1, 0, 0};
        vecs[2]  = '{4'h3, 0, 0, 1, 0, 0};
        vecs[3]  = '{4'h3, 1, 0, 2, 0, 0};
        vecs[4]  = '{4'h7, 0, 0, 2, 0, 0};
        vecs[5]  = '{4'h7, 1, 0, 3, 0, 0};
        vecs[6]  = '{4'hC, 0, 0, 3, 0, 0};
        vecs[7]  = '{4'hC, 1, 0, 4, 1, 0};
        vecs[8]  = '{4'h5, 0, 0, 4, 1, 0};
        vecs[9]  = '{4'h5, 1, 0, 4, 1, 1};
        vecs[10] = '{4'h5, 0, 0, 4, 1, 1};
        vecs[11] = '{4'h5, 0, 1, 0, 0, 0};
        vecs[12] = '{4'h9, 1, 1, 0, 0, 0};
        vecs[13] = '{4'h9, 1, 0, 0, 0, 0};
        vecs[14] = '{4'h9, 0, 0, 0, 0, 0};

        seqN     = '{4'h3, 4'h7, 4'hC, 4'hF};
        wantSeen = '{7'b0001110, 7'b1000110, 7'b1111000, 7'b0110000};

        reset = 1'b1;
        applyStimulus(4'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset hex_seg", 32'(hex_seg), 32'h7F);
        checkOutput("reset digit_en", 32'(digit_en), 32'hF);
        checkOutput("reset count", 32'(count), 32'd0);
        checkOutput("reset overflow", 32'(overflow), 32'd0);
        reset = 1'b0;
        modelReset();

        // Let the empty display scan for a couple of full rotations.
        for (int c = 0; c < 2 * 4 * R; c++) tick();

        // Table: held-level capture, fill to full, overflow, clear, clear vs capture.
        for (int v = 0; v < 15; v++) begin
            applyStimulus(vecs[v].din, vecs[v].cap, vecs[v].clr);
            tick();
            checkOutput($sformatf("vec%0d count", v), 32'(count), 32'(vecs[v].eCount));
            checkOutput($sformatf("vec%0d full", v), 32'(full), 32'(vecs[v].eFull));
            checkOutput($sformatf("vec%0d overflow", v), 32'(overflow), 32'(vecs[v].eOvf));
        end

        // Capture 3, 7, C, F and confirm what each digit displays.
        for (int s = 0; s < 4; s++) begin
            applyStimulus(seqN[s], 1, 0);
            tick();
            applyStimulus(seqN[s], 0, 0);
            tick();
        end
        checkOutput("filled count", 32'(count), 32'd4);
        checkOutput("filled full", 32'(full), 32'd1);
        for (int d = 0; d < 4; d++) seen[d] = 7'h7F;
        for (int c = 0; c < 2 * 4 * R; c++) begin
            tick();
            for (int d = 0; d < 4; d++)
                if (digit_en == ~(4'b0001 << d)) seen[d] = hex_seg;
        end
        for (int d = 0; d < 4; d++)
            checkOutput($sformatf("digit%0d glyph", d), 32'(seen[d]), 32'(wantSeen[d]));

        // Reset in the middle of the scan while digit 2 is lit.
        n = 0;
        while (digit_en !== 4'b1011 && n < 8 * R) begin
            tick();
            n++;
        end
        checkOutput("reach digit2 before timeout", 32'(digit_en == 4'b1011), 32'd1);
        checkOutput("digit2 lit before reset", 32'(hex_seg), 32'b1111000);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("async reset hex_seg", 32'(hex_seg), 32'h7F);
        checkOutput("async reset digit_en", 32'(digit_en), 32'hF);
        checkOutput("async reset count", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(4'h0, 0, 0);
        reset = 1'b0;
        modelReset();
        tick();
        checkOutput("first lit digit_en", 32'(digit_en), 32'hE);
        checkOutput("first lit hex_seg", 32'(hex_seg), 32'h7F);

        // Randomised traffic against the model.
        for (int c = 0; c < 600; c++) begin
            applyStimulus(4'($urandom), ($urandom_range(0, 2) == 0) ? !capture : capture,
                          $urandom_range(0, 40) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
